// File: rtl/mux4_rr_sel_gen_pkg.sv
// Shared constants, FSM state type and helpers for the 4:1 mux select generator.
package mux4_rr_sel_gen_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_CH-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mux4_rr_sel_gen_rr_pick4.sv
// Rotating-priority 4-way pick: first set req[i] scanning i = ptr, ptr+1, ... mod 4.
module rr_pick4
    import mux4_rr_sel_gen_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest position back to ptr so the closest hit wins last.
    always_comb begin
        found = |req;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sel_gen.sv
// Round-robin select/grant generator for the 4:1 mux, holding each grant for up to
// BURST_LEN accepted beats with a valid/ready handshake toward the consumer.
module mux4_rr_sel_gen
    import mux4_rr_sel_gen_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              out_valid,
    output logic [CNT_W-1:0]  beat_cnt,
    output state_t            state
);

    // Handshake: a beat transfers on any cycle where out_valid && out_ready are both
    // high at the rising edge; out_valid never depends on out_ready.

    state_t            state_next;
    logic [SEL_W-1:0]  sel_next;
    logic [NUM_CH-1:0] grant_next;
    logic [SEL_W-1:0]  ptr, ptr_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              accept;
    logic              last_beat;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign out_valid = (state == ST_GRANT) && req[sel];
    assign accept    = out_valid && out_ready;
    assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel      <= '0;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            grant    <= grant_next;
            ptr      <= ptr_next;
            beat_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        grant_next = grant;
        ptr_next   = ptr;
        cnt_next   = beat_cnt;
        unique case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_GRANT;
                    sel_next   = pick_idx;
                    grant_next = sel_onehot(pick_idx);
                    cnt_next   = '0;
                end
            end
            ST_GRANT: begin
                // Withdrawal releases without counting a beat; otherwise release on the last accept.
                if (!req[sel] || (accept && last_beat)) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    cnt_next   = '0;
                    ptr_next   = sel + SEL_W'(1);
                end else if (accept) begin
                    cnt_next = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux4_rr_sel_gen.sv
// Bench for mux4_rr_sel_gen: directed table, corner-case sequences and random traffic
// against an integer-level round-robin model.
module tb_mux4_rr_sel_gen;

    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 3;
    localparam int W         = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = '0;
    logic             out_ready = 1'b0;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic             out_valid;
    logic [CNT_W-1:0] beat_cnt;
    logic             dut_state;

    int checks = 0;
    int errors = 0;

    // model: granted channel (-1 = none), last select, rotation pointer, beats this grant
    int m_gnt, m_sel, m_ptr, m_cnt;

    logic [W-1:0] exp_q[$];
    logic [1:0]   last_sel;
    logic [3:0]   last_grant;
    logic         last_valid;
    logic [2:0]   last_cnt;

    mux4_rr_sel_gen #(.BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .beat_cnt  (beat_cnt),
        .state     (dut_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
    endtask

    function automatic logic [W-1:0] model_expect(input logic [3:0] r);
        logic [3:0] g;
        logic       v;
        g = (m_gnt >= 0) ? 4'(1 << m_gnt) : 4'd0;
        v = (m_gnt >= 0) && r[m_gnt];
        return {(m_gnt >= 0), 2'(m_sel), g, v, 3'(m_cnt)};
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rdy);
        if (m_gnt < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_gnt < 0 && r[(m_ptr + k) % 4]) begin
                    m_gnt = (m_ptr + k) % 4;
                    m_sel = m_gnt;
                    m_cnt = 0;
                end
            end
        end else if (!r[m_gnt] || (rdy && m_cnt + 1 == BURST_LEN)) begin
            m_ptr = (m_gnt + 1) % 4;
            m_gnt = -1;
            m_cnt = 0;
        end else if (rdy) begin
            m_cnt = m_cnt + 1;
        end
    endtask

    // One clock: apply inputs, compare at the falling edge, advance model at the rising edge.
    task automatic cycle(input logic [3:0] r, input logic rdy);
        logic [W-1:0] e;
        req = r;
        out_ready = rdy;
        exp_q.push_back(model_expect(r));
        @(negedge clk);
        e = exp_q.pop_front();
        last_sel = sel; last_grant = grant; last_valid = out_valid; last_cnt = beat_cnt;
        chk("state", dut_state, e[10]);
        chk("sel", sel, e[9:8]);
        chk("grant", grant, e[7:4]);
        chk("out_valid", out_valid, e[3]);
        chk("beat_cnt", beat_cnt, e[2:0]);
        @(posedge clk);
        model_step(r, rdy);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r_during);
        req = r_during;
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_sel", sel, 2'd0);
            chk("rst_grant", grant, 4'd0);
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_cnt", beat_cnt, 3'd0);
        end
        req = '0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       ready;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic [2:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic [1:0] s,
                                input logic [3:0] g, input logic v, input logic [2:0] c);
        vec_t t;
        t.req = r; t.ready = rd; t.sel = s; t.grant = g; t.valid = v; t.cnt = c;
        return t;
    endfunction

    initial begin
        vec_t tbl[15];
        int   starts[$];
        int   chans[$];
        logic [3:0] prev_g;

        tbl[0]  = mk(4'b0100, 1, 2'd0, 4'b0000, 0, 3'd0);
        tbl[1]  = mk(4'b0100, 1, 2'd2, 4'b0100, 1, 3'd0);
        tbl[2]  = mk(4'b0100, 1, 2'd2, 4'b0100, 1, 3'd1);
        tbl[3]  = mk(4'b0100, 1, 2'd2, 4'b0100, 1, 3'd2);
        tbl[4]  = mk(4'b0100, 1, 2'd2, 4'b0100, 1, 3'd3);
        tbl[5]  = mk(4'b0100, 1, 2'd2, 4'b0000, 0, 3'd0);
        tbl[6]  = mk(4'b0100, 1, 2'd2, 4'b0100, 1, 3'd0);
        tbl[7]  = mk(4'b0000, 1, 2'd2, 4'b0100, 0, 3'd1);
        tbl[8]  = mk(4'b0000, 1, 2'd2, 4'b0000, 0, 3'd0);
        tbl[9]  = mk(4'b1001, 0, 2'd2, 4'b0000, 0, 3'd0);
        tbl[10] = mk(4'b1001, 0, 2'd3, 4'b1000, 1, 3'd0);
        tbl[11] = mk(4'b1001, 1, 2'd3, 4'b1000, 1, 3'd0);
        tbl[12] = mk(4'b0001, 1, 2'd3, 4'b1000, 0, 3'd1);
        tbl[13] = mk(4'b0001, 1, 2'd3, 4'b0000, 0, 3'd0);
        tbl[14] = mk(4'b0001, 1, 2'd0, 4'b0001, 1, 3'd0);

        model_reset();
        do_reset(4'b1111);

        // Directed table: single requester bursts, withdraw, rotation after ch3.
        foreach (tbl[i]) begin
            cycle(tbl[i].req, tbl[i].ready);
            chk($sformatf("tbl%0d_sel", i), last_sel, tbl[i].sel);
            chk($sformatf("tbl%0d_grant", i), last_grant, tbl[i].grant);
            chk($sformatf("tbl%0d_valid", i), last_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_cnt", i), last_cnt, tbl[i].cnt);
        end

        // Full load: ch0..ch3 then ch0 again, 20 cycles between ch0 grants.
        do_reset(4'b0000);
        prev_g = '0;
        for (int i = 0; i < 23; i++) begin
            cycle(4'b1111, 1'b1);
            if (last_grant != 4'd0 && prev_g == 4'd0) begin
                starts.push_back(i);
                chans.push_back($clog2(int'(last_grant)));
            end
            prev_g = last_grant;
        end
        chk("full_nstarts", starts.size(), 5);
        if (starts.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("full_ch%0d", k), chans[k], k % 4);
            chk("full_regrant_dist", starts[4] - starts[0], 20);
        end

        // Backpressure after beat 2.
        do_reset(4'b0000);
        repeat (3) cycle(4'b0001, 1'b1);
        repeat (3) begin
            cycle(4'b0001, 1'b0);
            chk("bp_cnt_hold", last_cnt, 3'd2);
            chk("bp_grant", last_grant, 4'b0001);
            chk("bp_valid", last_valid, 1'b1);
        end
        cycle(4'b0001, 1'b1);
        cycle(4'b0001, 1'b1);
        chk("bp_last_cnt", last_cnt, 3'd3);
        cycle(4'b0001, 1'b1);
        chk("bp_release", last_grant, 4'b0000);

        // Withdraw of ch1 after 2 beats; ptr moves to ch2, which beats ch0.
        do_reset(4'b0000);
        repeat (3) cycle(4'b0010, 1'b1);
        cycle(4'b0101, 1'b1);
        chk("wd_valid", last_valid, 1'b0);
        chk("wd_cnt", last_cnt, 3'd2);
        cycle(4'b0101, 1'b1);
        chk("wd_release", last_grant, 4'b0000);
        cycle(4'b0101, 1'b1);
        chk("wd_next", last_grant, 4'b0100);

        // Asynchronous reset at beat 2 of ch3.
        do_reset(4'b0000);
        repeat (3) cycle(4'b1000, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("arst_sel", sel, 2'd0);
        chk("arst_grant", grant, 4'd0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_cnt", beat_cnt, 3'd0);
        req = 4'b1111;
        #1 rst = 1'b0;
        model_reset();
        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b1);
        chk("arst_ch0_first", last_grant, 4'b0001);

        // Random traffic with sticky requests.
        do_reset(4'b0000);
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                cycle(r, $urandom_range(0, 3) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
